// File: rtl/player_input.sv
// PS/2 set-2 scan-code parser that turns left/right/jump keys into gameplay controls.
// o_dbg_state exposes the parser state: 0=IDLE, 1=EXT, 2=BRK, 3=EXT_BRK.
module player_input #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       start_game,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic [1:0] o_dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_decode;
    logic            w_ext;
    logic            w_brk;
    logic [5:0]      w_hit;
    logic [5:0]      r_flags;
    logic [5:0]      w_flags_nxt;
    logic            w_left_held;
    logic            w_right_held;
    logic            w_jump_pulse;
    logic            r_left;
    logic            r_right;
    logic            r_jump;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_decode    = 1'b0;
        if (scan_valid) begin
            w_cnt_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (scan_code == 8'hE0)      w_state_nxt = S_EXT;
                    else if (scan_code == 8'hF0) w_state_nxt = S_BRK;
                    else begin
                        w_decode    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (scan_code == 8'hE0)      w_state_nxt = S_EXT;
                    else if (scan_code == 8'hF0) w_state_nxt = S_EXT_BRK;
                    else begin
                        w_decode    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    if (scan_code != 8'hF0) begin
                        w_decode    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end else if (r_state != S_IDLE) begin
            // An abandoned prefix falls back to IDLE without touching any flag.
            if (r_cnt == TO_LAST) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else begin
            w_cnt_nxt = '0;
        end
    end

    assign w_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    assign w_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

    // One-hot key hit: {jump_ext, jump_plain, right_ext, right_plain, left_ext, left_plain}.
    always_comb begin
        w_hit = 6'b0;
        if (w_decode) begin
            w_hit[0] = !w_ext && (scan_code == 8'h1C);
            w_hit[1] =  w_ext && (scan_code == 8'h6B);
            w_hit[2] = !w_ext && (scan_code == 8'h23);
            w_hit[3] =  w_ext && (scan_code == 8'h74);
            w_hit[4] = !w_ext && (scan_code == 8'h29);
            w_hit[5] =  w_ext && (scan_code == 8'h75);
        end
    end

    assign w_flags_nxt  = w_brk ? (r_flags & ~w_hit) : (r_flags | w_hit);
    assign w_left_held  = |w_flags_nxt[1:0];
    assign w_right_held = |w_flags_nxt[3:2];
    // Only a fresh press pulses; typematic repeats find a jump flag already set.
    assign w_jump_pulse = start_game && !w_brk && (|w_hit[5:4]) && !(|r_flags[5:4]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_flags <= 6'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_jump  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_flags <= w_flags_nxt;
            r_left  <= start_game && w_left_held && !w_right_held;
            r_right <= start_game && w_right_held && !w_left_held;
            r_jump  <= w_jump_pulse;
        end
    end

    assign left        = r_left;
    assign right       = r_right;
    assign jump        = r_jump;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: directed key scenarios plus random byte streams checked
// against a per-byte model of the scan-code rules.
module tb_player_input;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       start_game = 1'b0;
  logic       left;
  logic       right;
  logic       jump;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int pulses;

  // reference model: held keys by name, pending prefixes, idle gap length
  bit m_lp, m_le, m_rp, m_re, m_jp, m_je;
  bit m_ext, m_brk, m_pulse;
  int m_gap;

  // clock / reset block
  always #5 clk = ~clk;

  player_input #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .scan_code(scan_code),
    .scan_valid(scan_valid),
    .start_game(start_game),
    .left(left),
    .right(right),
    .jump(jump),
    .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_lp, m_le, m_rp, m_re, m_jp, m_je} = 6'b0;
    m_ext = 0;
    m_brk = 0;
    m_pulse = 0;
    m_gap = 0;
  endtask

  function automatic bit exp_left();
    return start_game && (m_lp || m_le) && !(m_rp || m_re);
  endfunction

  function automatic bit exp_right();
    return start_game && (m_rp || m_re) && !(m_lp || m_le);
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".left"}, left, exp_left());
    check({tag, ".right"}, right, exp_right());
    check({tag, ".jump"}, jump, m_pulse);
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit is_make;
    m_pulse = 0;
    m_gap = 0;
    if (b == 8'hE0 && !m_brk) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      is_make = !m_brk;
      if (!m_ext && b == 8'h1C) m_lp = is_make;
      if ( m_ext && b == 8'h6B) m_le = is_make;
      if (!m_ext && b == 8'h23) m_rp = is_make;
      if ( m_ext && b == 8'h74) m_re = is_make;
      if ((!m_ext && b == 8'h29) || (m_ext && b == 8'h75)) begin
        if (is_make && start_game && !m_jp && !m_je) m_pulse = 1;
        if (!m_ext) m_jp = is_make;
        else        m_je = is_make;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // driver tasks
  task automatic idle_tick();
    @(posedge clk);
    #1;
    m_pulse = 0;
    if (m_ext || m_brk) begin
      m_gap++;
      if (m_gap >= T) begin
        m_ext = 0;
        m_brk = 0;
      end
    end
    check_outs("idle");
  endtask

  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
    model_byte(b);
    check_outs($sformatf("byte_%02h", b));
  endtask

  task automatic send_gap(input logic [7:0] b, input int g);
    repeat (g) idle_tick();
    send(b);
  endtask

  logic [7:0] pool [9] = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h29, 8'h6B, 8'h74, 8'h75, 8'h12};

  initial begin
    model_reset();
    #2;
    check("reset.left", left, 1'b0);
    check("reset.right", right, 1'b0);
    check("reset.jump", jump, 1'b0);
    check("reset.state_idle", dbg_state == 2'd0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_tick();

    // plain left make/break
    start_game = 1'b1;
    send(8'h1C);
    check("r26.left_on", left, 1'b1);
    send(8'hF0);
    send(8'h1C);
    check("r26.left_off", left, 1'b0);
    idle_tick();

    // extended right with plain right overlap
    send(8'hE0); send(8'h74);
    check("r27.right_on", right, 1'b1);
    send(8'h23);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("r27.right_still", right, 1'b1);
    send(8'hF0); send(8'h23);
    check("r27.right_off", right, 1'b0);

    // jump pulses with typematic repeats
    pulses = 0;
    send(8'h29); pulses += int'(jump); idle_tick(); pulses += int'(jump);
    send(8'h29); pulses += int'(jump); idle_tick(); pulses += int'(jump);
    send(8'h29); pulses += int'(jump); idle_tick(); pulses += int'(jump);
    send(8'hF0); send(8'h29); pulses += int'(jump);
    send(8'h29); pulses += int'(jump); idle_tick(); pulses += int'(jump);
    check("r28.two_pulses", pulses == 2, 1'b1);
    send(8'hF0); send(8'h29);

    // opposing directions cancel
    send(8'h1C);
    check("r29.left", left, 1'b1);
    send(8'h23);
    check("r29.both_left", left, 1'b0);
    check("r29.both_right", right, 1'b0);
    send(8'hF0); send(8'h1C);
    check("r29.right", right, 1'b1);
    send(8'hF0); send(8'h23);

    // prefix timeout at exactly T idle cycles
    send(8'hE0);
    repeat (T) idle_tick();
    check("r30.timeout_idle", dbg_state == 2'd0, 1'b1);
    send(8'h6B);
    check("r30.6b_ignored", left, 1'b0);
    start_game = 1'b0;
    send(8'h1C); send(8'h23); send(8'h75);
    start_game = 1'b1;
    idle_tick();
    check("r30.game_left", left, 1'b0);
    check("r30.game_right", right, 1'b0);
    check("r30.game_jump", jump, 1'b0);
    send(8'hF0); send(8'h1C);
    check("r30.right_after", right, 1'b1);
    send(8'hF0); send(8'h23);

    // one cycle short of the timeout keeps the prefix
    send(8'hE0);
    repeat (T - 1) idle_tick();
    check("edge.still_prefix", dbg_state != 2'd0, 1'b1);
    send(8'h6B);
    check("edge.ext_left", left, 1'b1);

    // reset mid-sequence clears flags and the pending prefix
    send(8'hE0);
    rst = 1'b0;
    #1;
    model_reset();
    check("r31.async_left", left, 1'b0);
    check("r31.async_state", dbg_state == 2'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'hF0); send(8'h6B);
    check("r31.left", left, 1'b0);
    check("r31.state", dbg_state == 2'd0, 1'b1);

    // random byte streams with gaps straddling the timeout
    for (int i = 0; i < 400; i++) begin
      int g;
      if ($urandom_range(0, 15) == 0) start_game = ~start_game;
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 2);
      send_gap(pool[$urandom_range(0, 8)], g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
